fsmc_bus_master: RTL and testbench
==================================

Name: fsmc_bus_master

Overview:
- Initiator end of the 8-bit FSMC-style register bus used by the motor CPLD. It turns command-port requests into timed bus cycles on addr / data / select_n / read_n / write_n.
- Used in the FPGA main controller and in system benches to drive the motor-board register map: interrupt clear at 0/1, staging byte at 2, control/count registers, CDC outputs.
- Supports byte reads and byte writes.
- Also supports an atomic 16-bit write: the staging-byte write followed by the target write, with no other bus cycle allowed in between.

Parameters:
SETUP_CYC, 2, clk cycles with select_n low and address/data stable before the strobe; legal 1..15
STROBE_CYC, 4, clk cycles read_n/write_n is held low; legal 1..15
HOLD_CYC, 2, clk cycles after the strobe rises, with select_n, addr and data still held; legal 1..15
TURN_CYC, 1, clk cycles select_n is high with data released between bus cycles; legal 1..15
STAGE_ADDR, 8'd2, address of the low-byte staging register used by 16-bit writes

Ports:
clk  in  1  system clock
reset_n  in  1  reset
cmd_valid  in  1  command request
cmd_ready  out  1  master idle, command accepted on the clock edge where valid&&ready
cmd_op  in  2  00 read, 01 write8, 10 write16, 11 reserved
cmd_addr  in  8  target register address
cmd_wdata  in  16  write data; write8 uses [7:0]
rsp_valid  out  1  single-cycle completion pulse
rsp_rdata  out  8  read data, held until the next read completes
rsp_err  out  1  valid with rsp_valid; 1 means reserved op
bus_addr  out  8  bus address
bus_data_o  out  8  write data to the pad
bus_data_oe  out  1  pad output enable; top level builds the inout
bus_data_i  in  8  read data from the pad
bus_select_n  out  1  chip select, active low
bus_read_n  out  1  read strobe, active low
bus_write_n  out  1  write strobe, active low

Behaviour:
- Reset is asynchronous and active-low (reset_n); the clock is clk.
- Reset values:
  - bus_select_n = bus_read_n = bus_write_n = 1.
  - bus_data_oe = 0; bus_addr = 0; bus_data_o = 0.
  - rsp_valid = 0; rsp_err = 0; rsp_rdata = 0.
  - cmd_ready = 1; FSM in IDLE.
- All bus outputs are registered so they are glitch-free.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> TURN -> (IDLE | SETUP for phase 2).
  - One 4-bit down-counter sets dwell time, loaded with PARAM-1 on entry to each state.
- cmd_ready = 1 only in IDLE. On accept, op, addr and wdata are latched, so inputs may change afterwards.
- SETUP:
  - select_n = 0; bus_addr driven.
  - Strobes stay high.
  - For writes, oe = 1 and data_o is valid.
- STROBE: read_n = 0 (read) or write_n = 0 (write). Address and data do not change.
- Read capture: bus_data_i is sampled into the rdata holding register in the last STROBE cycle, i.e. the edge on which read_n returns high.
- HOLD:
  - Strobes high; select_n = 0.
  - addr, data_o and oe are unchanged.
- TURN: select_n = 1; oe = 0; bus_addr keeps its old value.
- Single-phase timing: accept at edge k, SETUP occupies cycles k+1..k+SETUP_CYC, and the rest follows in sequence. rsp_valid is high in the first IDLE cycle after TURN, which is cycle k+1+S+P+H+T (defaults: k+10).
- write16:
  - Phase 1: addr = STAGE_ADDR, data = wdata[7:0].
  - Full TURN between phases.
  - Phase 2: addr = cmd_addr, data = wdata[15:8].
  - Single rsp_valid after phase 2 only (defaults: k+19). cmd_ready stays low for the whole sequence.
- rsp_rdata updates only on read completion. On write completion it keeps its last value; rsp_err = 0.
- Reserved op 11: accepted, no bus activity. rsp_valid = 1 with rsp_err = 1 in the next cycle (k+1).
- Back-to-back: if cmd_valid is high in the rsp_valid cycle, the command is accepted on that edge. The select_n high gap is therefore TURN_CYC+1 cycles.
- Strobe-width guarantees:
  - Strobes never overlap.
  - A strobe is never low while select_n is high.
  - Address never changes while select_n is low.
- Reset mid-operation: all bus outputs go to idle values immediately (asynchronously). The aborted command produces no rsp_valid.

Test Plan:
- Read at addr 4, bus_data_i = 8'h55 from SETUP onward, defaults -> read_n low for exactly 4 cycles; rsp_valid at k+10 with rsp_rdata = 8'h55, rsp_err = 0.
- write8 at addr 27, wdata 16'h00A5 -> write_n low for 4 cycles with bus_data_o = 8'hA5 and addr = 27. oe high from SETUP through HOLD (8 cycles); rsp_valid at k+10.
- write16 at addr 3, wdata 16'h1234 -> phase 1 addr 2 data 8'h34, phase 2 addr 3 data 8'h12. select_n high for 1 cycle between phases; one rsp_valid at k+19.
- Two reads issued with cmd_valid held high, SETUP=1 STROBE=1 HOLD=1 TURN=3 -> select_n high gap of 4 cycles; second rsp_rdata reflects bus_data_i at the second strobe; no strobe overlap.
- cmd_op = 11 at addr 9 -> no select_n activity; rsp_valid with rsp_err = 1 at k+1; rsp_rdata unchanged.
- reset_n asserted during the STROBE of a write16 phase 1 -> all strobes and select_n high and oe = 0 within the same cycle. No rsp_valid; after release, cmd_ready = 1 and a new read completes normally.

Source files
------------

// File: rtl/fsmc_bus_master_if.sv
// fsmc_bus_master_if: command/response handshake plus FSMC-style bus pins
interface fsmc_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [7:0]  bus_addr;
  logic [7:0]  bus_data_o;
  logic        bus_data_oe;
  logic [7:0]  bus_data_i;
  logic        bus_select_n;
  logic        bus_read_n;
  logic        bus_write_n;
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, bus_data_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_addr, bus_data_o, bus_data_oe, bus_select_n, bus_read_n, bus_write_n
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, bus_data_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_addr, bus_data_o, bus_data_oe, bus_select_n, bus_read_n, bus_write_n
  );
endinterface

// File: rtl/fsmc_bus_master.sv
// fsmc_bus_master: turns command requests into timed 8-bit FSMC-style bus cycles
module fsmc_bus_master #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned TURN_CYC   = 1,
  parameter logic [7:0]  STAGE_ADDR = 8'd2
) (
  input logic clk,
  input logic reset_n,
  fsmc_bus_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;
  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_W8  = 2'b01;
  localparam logic [1:0] OP_W16 = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [3:0] S_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] P_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] H_LD = 4'(HOLD_CYC - 1);
  localparam logic [3:0] T_LD = 4'(TURN_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  cap_q, cap_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  baddr_q, baddr_d;
  logic [7:0]  bdata_q, bdata_d;
  logic        oe_q, oe_d;
  logic        sel_n_q, sel_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        accept, done, active, is_wr, enter;

  // Next-state logic: each bus phase dwells for its parameter count via one shared down-counter
  always_comb begin
    accept  = state_q == IDLE && bus.cmd_valid;
    op_d    = accept ? bus.cmd_op : op_q;
    addr_d  = accept ? bus.cmd_addr : addr_q;
    wdata_d = accept ? bus.cmd_wdata : wdata_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    done    = 1'b0;
    case (state_q)
      IDLE:
        if (accept && bus.cmd_op != OP_RSV) begin
          state_d = SETUP;
          cnt_d   = S_LD;
          phase_d = 1'b0;
        end
      SETUP:
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = P_LD;
        end else cnt_d = cnt_q - 4'd1;
      STROBE:
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          cnt_d   = H_LD;
        end else cnt_d = cnt_q - 4'd1;
      HOLD:
        if (cnt_q == 4'd0) begin
          state_d = TURN;
          cnt_d   = T_LD;
        end else cnt_d = cnt_q - 4'd1;
      TURN:
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else if (op_q == OP_W16 && !phase_q) begin
          state_d = SETUP;
          cnt_d   = S_LD;
          phase_d = 1'b1;
        end else begin
          state_d = IDLE;
          done    = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end

  // Bus pin and response next values derived from the next state so the pins can be registered
  always_comb begin
    active      = state_d == SETUP || state_d == STROBE || state_d == HOLD;
    is_wr       = op_d == OP_W8 || op_d == OP_W16;
    enter       = state_d == SETUP && state_q != SETUP;
    sel_n_d     = !active;
    rd_n_d      = !(state_d == STROBE && op_d == OP_RD);
    wr_n_d      = !(state_d == STROBE && is_wr);
    oe_d        = active && is_wr;
    baddr_d     = enter ? ((op_d == OP_W16 && !phase_d) ? STAGE_ADDR : addr_d) : baddr_q;
    bdata_d     = enter ? ((op_d == OP_W16 && phase_d) ? wdata_d[15:8] : wdata_d[7:0]) : bdata_q;
    cap_d       = (state_q == STROBE && cnt_q == 4'd0 && op_q == OP_RD) ? bus.bus_data_i : cap_q;
    rsp_valid_d = done || (accept && bus.cmd_op == OP_RSV);
    rsp_err_d   = accept && bus.cmd_op == OP_RSV;
    rdata_d     = (done && op_q == OP_RD) ? cap_q : rdata_q;
  end

  // State and output registers; reset drops every bus pin to idle immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      phase_q     <= 1'b0;
      op_q        <= 2'b00;
      addr_q      <= 8'd0;
      wdata_q     <= 16'd0;
      cap_q       <= 8'd0;
      rdata_q     <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      baddr_q     <= 8'd0;
      bdata_q     <= 8'd0;
      oe_q        <= 1'b0;
      sel_n_q     <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cap_q       <= cap_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      baddr_q     <= baddr_d;
      bdata_q     <= bdata_d;
      oe_q        <= oe_d;
      sel_n_q     <= sel_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
    end
  end

  assign bus.cmd_ready    = state_q == IDLE;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.bus_addr     = baddr_q;
  assign bus.bus_data_o   = bdata_q;
  assign bus.bus_data_oe  = oe_q;
  assign bus.bus_select_n = sel_n_q;
  assign bus.bus_read_n   = rd_n_q;
  assign bus.bus_write_n  = wr_n_q;
endmodule

// File: tb/tb_fsmc_bus_master.sv
// tb_fsmc_bus_master: directed checks of bus timing, write16 sequencing, reserved op and reset abort
module tb_fsmc_bus_master;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dsel = 1'b0;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_addr = 8'd0;
  logic [15:0] cmd_wdata = 16'd0;
  logic [7:0] bus_data_i = 8'd0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fsmc_bus_master_if if0();
  fsmc_bus_master_if if1();

  assign if0.cmd_valid = cmd_valid & ~dsel;
  assign if1.cmd_valid = cmd_valid & dsel;
  assign if0.cmd_op = cmd_op;
  assign if1.cmd_op = cmd_op;
  assign if0.cmd_addr = cmd_addr;
  assign if1.cmd_addr = cmd_addr;
  assign if0.cmd_wdata = cmd_wdata;
  assign if1.cmd_wdata = cmd_wdata;
  assign if0.bus_data_i = bus_data_i;
  assign if1.bus_data_i = bus_data_i;

  fsmc_bus_master u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  fsmc_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .TURN_CYC(3))
    u1 (.clk(clk), .reset_n(reset_n), .bus(if1));

  logic o_ready, o_rv, o_err, o_oe, o_sel, o_rd, o_wr;
  logic [7:0] o_rdata, o_addr, o_dout;
  assign o_ready = dsel ? if1.cmd_ready : if0.cmd_ready;
  assign o_rv    = dsel ? if1.rsp_valid : if0.rsp_valid;
  assign o_err   = dsel ? if1.rsp_err : if0.rsp_err;
  assign o_rdata = dsel ? if1.rsp_rdata : if0.rsp_rdata;
  assign o_addr  = dsel ? if1.bus_addr : if0.bus_addr;
  assign o_dout  = dsel ? if1.bus_data_o : if0.bus_data_o;
  assign o_oe    = dsel ? if1.bus_data_oe : if0.bus_data_oe;
  assign o_sel   = dsel ? if1.bus_select_n : if0.bus_select_n;
  assign o_rd    = dsel ? if1.bus_read_n : if0.bus_read_n;
  assign o_wr    = dsel ? if1.bus_write_n : if0.bus_write_n;

  int rd_low, wr_low, oe_cnt, sel_low, viol, rsp_cnt, rsp_cyc, gap, cur_high;
  logic seen_low, prev_sel, rsp_err_v;
  logic [7:0] prev_addr, wa1, wd1, wa2, wd2, rd_first, rd_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rd_low = 0; wr_low = 0; oe_cnt = 0; sel_low = 0; viol = 0; rsp_cnt = 0; rsp_cyc = 0;
    gap = 0; cur_high = 0; seen_low = 1'b0; prev_sel = 1'b1; prev_addr = 8'd0; rsp_err_v = 1'b0;
    wa1 = 8'd0; wd1 = 8'd0; wa2 = 8'd0; wd2 = 8'd0; rd_first = 8'd0; rd_last = 8'd0;
  endtask

  task automatic obs(input int c);
    if (!o_rd) rd_low++;
    if (!o_wr) begin
      wr_low++;
      if (wr_low == 1) begin wa1 = o_addr; wd1 = o_dout; end
      wa2 = o_addr; wd2 = o_dout;
    end
    if (o_oe) oe_cnt++;
    if (!o_rd && !o_wr) viol++;
    if ((!o_rd || !o_wr) && o_sel) viol++;
    if (!o_sel && !prev_sel && o_addr != prev_addr) viol++;
    if (!o_sel) begin
      sel_low++;
      if (seen_low && cur_high > 0) gap = cur_high;
      cur_high = 0;
      seen_low = 1'b1;
    end else if (seen_low) cur_high++;
    if (o_rv) begin
      rsp_cnt++;
      if (rsp_cnt == 1) begin rsp_cyc = c; rd_first = o_rdata; end
      rsp_err_v = o_err;
      rd_last = o_rdata;
    end
    prev_sel = o_sel;
    prev_addr = o_addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [15:0] wd, input int n);
    cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'b01; cmd_addr = 8'hFF; cmd_wdata = 16'hDEAD;
    clr();
    for (int c = 1; c <= n; c++) begin
      obs(c);
      tick();
    end
  endtask

  initial begin
    int acc;
    bit hit;
    tick();
    tick();
    chk("rst_sel", o_sel, 1'b1);
    chk("rst_rd", o_rd, 1'b1);
    chk("rst_wr", o_wr, 1'b1);
    chk("rst_oe", o_oe, 1'b0);
    chk("rst_addr", o_addr, 8'd0);
    chk("rst_dout", o_dout, 8'd0);
    chk("rst_rv", o_rv, 1'b0);
    chk("rst_err", o_err, 1'b0);
    chk("rst_rdata", o_rdata, 8'd0);
    chk("rst_ready", o_ready, 1'b1);
    reset_n = 1'b1;
    tick();

    bus_data_i = 8'h55;
    run_cmd(2'b00, 8'd4, 16'h0000, 14);
    chk("rd_strobe_len", rd_low, 4);
    chk("rd_no_wr", wr_low, 0);
    chk("rd_sel_len", sel_low, 8);
    chk("rd_rsp_cyc", rsp_cyc, 10);
    chk("rd_rsp_cnt", rsp_cnt, 1);
    chk("rd_rdata", rd_first, 8'h55);
    chk("rd_err", rsp_err_v, 1'b0);
    chk("rd_viol", viol, 0);

    bus_data_i = 8'h99;
    run_cmd(2'b01, 8'd27, 16'h00A5, 14);
    chk("w8_strobe_len", wr_low, 4);
    chk("w8_addr", wa1, 8'd27);
    chk("w8_data", wd1, 8'hA5);
    chk("w8_oe_len", oe_cnt, 8);
    chk("w8_rsp_cyc", rsp_cyc, 10);
    chk("w8_err", rsp_err_v, 1'b0);
    chk("w8_rdata_kept", rd_first, 8'h55);
    chk("w8_viol", viol, 0);

    run_cmd(2'b10, 8'd3, 16'h1234, 24);
    chk("w16_ph1_addr", wa1, 8'd2);
    chk("w16_ph1_data", wd1, 8'h34);
    chk("w16_ph2_addr", wa2, 8'd3);
    chk("w16_ph2_data", wd2, 8'h12);
    chk("w16_strobe_len", wr_low, 8);
    chk("w16_gap", gap, 1);
    chk("w16_rsp_cnt", rsp_cnt, 1);
    chk("w16_rsp_cyc", rsp_cyc, 19);
    chk("w16_viol", viol, 0);

    run_cmd(2'b11, 8'd9, 16'h0000, 4);
    chk("rsv_rsp_cyc", rsp_cyc, 1);
    chk("rsv_rsp_cnt", rsp_cnt, 1);
    chk("rsv_err", rsp_err_v, 1'b1);
    chk("rsv_rdata", rd_first, 8'h55);
    chk("rsv_no_sel", sel_low, 0);

    dsel = 1'b1;
    tick();
    bus_data_i = 8'h11;
    cmd_op = 2'b00; cmd_addr = 8'd5; cmd_valid = 1'b1;
    clr();
    acc = 0;
    for (int c = 1; c <= 25; c++) begin
      if (o_ready && cmd_valid) acc++;
      obs(c);
      if (rsp_cnt >= 1) bus_data_i = 8'h22;
      tick();
      if (acc == 2) cmd_valid = 1'b0;
    end
    chk("b2b_accepts", acc, 2);
    chk("b2b_rsp_cnt", rsp_cnt, 2);
    chk("b2b_rdata1", rd_first, 8'h11);
    chk("b2b_rdata2", rd_last, 8'h22);
    chk("b2b_gap", gap, 4);
    chk("b2b_strobes", rd_low, 2);
    chk("b2b_viol", viol, 0);

    dsel = 1'b0;
    tick();
    cmd_op = 2'b10; cmd_addr = 8'd7; cmd_wdata = 16'hBEEF; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (!o_wr) hit = 1'b1;
      else tick();
    end
    chk("rst_mid_strobe_seen", hit, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_sel", o_sel, 1'b1);
    chk("rst_mid_wr", o_wr, 1'b1);
    chk("rst_mid_rd", o_rd, 1'b1);
    chk("rst_mid_oe", o_oe, 1'b0);
    tick();
    reset_n = 1'b1;
    clr();
    for (int c = 1; c <= 25; c++) begin
      obs(c);
      tick();
    end
    chk("rst_mid_no_rsp", rsp_cnt, 0);
    chk("rst_mid_no_sel", sel_low, 0);
    chk("rst_mid_ready", o_ready, 1'b1);
    bus_data_i = 8'h66;
    run_cmd(2'b00, 8'd4, 16'h0000, 14);
    chk("post_rst_rsp_cyc", rsp_cyc, 10);
    chk("post_rst_rdata", rd_first, 8'h66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
